// File: rtl/timer_ctrl_unit_pkg.sv
// rtl/timer_ctrl_unit_pkg.sv - shared types and helpers for the min/sec timer control unit
//
// Contents:
//   state_t     : control FSM state encoding (also driven out on o_state for LEDs)
//   DIR_UP/DOWN : count direction values carried on o_dir
//   div_width() : bit width of the tick divider counter for a given divide ratio
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'b00,
        RUN   = 2'b01,
        CLEAR = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Counter must hold 0..div-1; never narrower than one bit.
    function automatic int div_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/timer_ctrl_unit_if.sv
// rtl/timer_ctrl_unit_if.sv - button/switch inputs and datapath controls of the timer control unit
//
// Signals:
//   i_btn_run_stop, i_btn_clear : debounced pushbutton levels, asynchronous to clk
//   i_mode_down                 : direction switch (0 = up, 1 = down)
//   i_time_zero                 : datapath reports time == 00:00
//   o_tick                      : one-cycle count enable to the datapath
//   o_run, o_clear, o_done      : state flags
//   o_dir                       : latched direction to the datapath
//   o_state                     : current state for debug/LED
// Modports:
//   slave  : the control unit
//   master : the surrounding buttons/switch/datapath
interface timer_ctrl_if;
    import timer_ctrl_pkg::*;

    logic   i_btn_run_stop;
    logic   i_btn_clear;
    logic   i_mode_down;
    logic   i_time_zero;
    logic   o_tick;
    logic   o_run;
    logic   o_clear;
    logic   o_dir;
    logic   o_done;
    state_t o_state;

    modport slave (
        input  i_btn_run_stop, i_btn_clear, i_mode_down, i_time_zero,
        output o_tick, o_run, o_clear, o_dir, o_done, o_state
    );

    modport master (
        output i_btn_run_stop, i_btn_clear, i_mode_down, i_time_zero,
        input  o_tick, o_run, o_clear, o_dir, o_done, o_state
    );

endinterface

// File: rtl/timer_ctrl_unit_btn_sync_edge.sv
// rtl/timer_ctrl_unit_btn_sync_edge.sv - button synchronizer and rising-edge pulse generator
//
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   i_btn   : debounced button level, asynchronous to clk
//   o_pulse : registered one-cycle pulse per press; a held button yields one pulse
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // sync_q1/sync_q2 form the metastability synchronizer; sync_q3 is the
    // previous synchronized level for edge detection. The pulse is registered,
    // so the FSM reacts on the third edge after the first high sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            sync_q1 <= i_btn;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
            o_pulse <= sync_q2 & ~sync_q3;
        end
    end

endmodule

// File: rtl/timer_ctrl_unit.sv
// rtl/timer_ctrl_unit.sv - run/stop/clear/done sequencer and gated timebase for the min/sec timer
//
// Parameters:
//   CLK_FREQ_HZ : system clock frequency
//   TICK_HZ     : count-enable rate; DIV = CLK_FREQ_HZ / TICK_HZ must be >= 2
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : timer_ctrl_if.slave - button/switch/time-zero inputs, tick/state outputs
module timer_ctrl_unit
    import timer_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);

    localparam int                DIV     = CLK_FREQ_HZ / TICK_HZ;
    localparam int                CNT_W   = div_width(DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("timer_ctrl_unit: CLK_FREQ_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic             run_pulse;
    logic             clr_pulse;
    logic             zero_hit;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    btn_sync_edge u_run_sync (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.i_btn_run_stop),
        .o_pulse (run_pulse)
    );

    btn_sync_edge u_clr_sync (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.i_btn_clear),
        .o_pulse (clr_pulse)
    );

    // Countdown has reached 00:00; only meaningful with the latched direction.
    assign zero_hit = (bus.o_dir == DIR_DOWN) && bus.i_time_zero;

    // Clear beats run in STOP/DONE; run beats clear in RUN (clear ignored there).
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP: begin
                if (clr_pulse)
                    state_d = CLEAR;
                else if (run_pulse && !zero_hit)
                    state_d = RUN;
            end
            RUN: begin
                if (run_pulse)
                    state_d = STOP;
                else if (zero_hit)
                    state_d = DONE;
            end
            CLEAR: state_d = STOP;
            DONE: begin
                if (clr_pulse)
                    state_d = CLEAR;
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STOP;
            cnt_q       <= '0;
            bus.o_tick  <= 1'b0;
            bus.o_run   <= 1'b0;
            bus.o_clear <= 1'b0;
            bus.o_done  <= 1'b0;
            bus.o_dir   <= DIR_UP;
            bus.o_state <= STOP;
        end else begin
            state_q     <= state_d;
            bus.o_state <= state_d;
            bus.o_run   <= (state_d == RUN);
            bus.o_clear <= (state_d == CLEAR);
            bus.o_done  <= (state_d == DONE);

            // Direction is frozen while counting so a mid-run switch flip
            // only applies after the next stop.
            if (state_q == STOP || state_q == CLEAR)
                bus.o_dir <= bus.i_mode_down;

            // The divider only advances on cycles that stay in RUN. Leaving RUN
            // freezes the phase (including at DIV-1), so resume picks up where
            // it paused and no tick can leak into STOP or DONE.
            bus.o_tick <= 1'b0;
            if (state_q == CLEAR) begin
                cnt_q <= '0;
            end else if (state_q == RUN && state_d == RUN) begin
                cnt_q      <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
                bus.o_tick <= (cnt_q == CNT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl_unit.sv
// tb/tb_timer_ctrl_unit.sv - self-checking bench for timer_ctrl_unit
module tb_timer_ctrl_unit;
    import timer_ctrl_pkg::*;

    localparam int DIV = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    timer_ctrl_if bus_if ();

    timer_ctrl_unit #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a button press takes effect 3 edges after its first
    // high sample, only on a low-to-high change. Tick phase is the number of
    // RUN-to-RUN cycles since the last clear, modulo DIV.
    state_t     m_state;
    logic       m_tick;
    logic       m_dir;
    int         m_runs;
    logic [4:1] m_rh;
    logic [4:1] m_ch;

    always @(posedge clk or posedge rst) begin : ref_model
        state_t nxt;
        logic   run_p;
        logic   clr_p;
        logic   zero;
        logic   stay_run;
        if (rst) begin
            m_state <= STOP;
            m_tick  <= 1'b0;
            m_dir   <= 1'b0;
            m_runs  <= 0;
            m_rh    <= '0;
            m_ch    <= '0;
        end else begin
            run_p = m_rh[3] & ~m_rh[4];
            clr_p = m_ch[3] & ~m_ch[4];
            zero  = m_dir & bus_if.i_time_zero;
            nxt   = m_state;
            if (m_state == STOP) begin
                if (clr_p) nxt = CLEAR;
                else if (run_p && !zero) nxt = RUN;
            end else if (m_state == RUN) begin
                if (run_p) nxt = STOP;
                else if (zero) nxt = DONE;
            end else if (m_state == CLEAR) begin
                nxt = STOP;
            end else begin
                if (clr_p) nxt = CLEAR;
            end
            stay_run = (m_state == RUN) && (nxt == RUN);
            m_tick <= stay_run && ((m_runs % DIV) == DIV - 1);
            if (m_state == CLEAR) m_runs <= 0;
            else if (stay_run) m_runs <= m_runs + 1;
            if (m_state == STOP || m_state == CLEAR) m_dir <= bus_if.i_mode_down;
            m_state <= nxt;
            m_rh <= {m_rh[3:1], bus_if.i_btn_run_stop};
            m_ch <= {m_ch[3:1], bus_if.i_btn_clear};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits up to limit cycles for o_tick; returns whether it was seen.
    task automatic wait_tick(input int limit, output bit seen);
        int n;
        n = 0;
        while (bus_if.o_tick !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        seen = (bus_if.o_tick === 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_if.i_btn_run_stop = 1'b0;
        bus_if.i_btn_clear    = 1'b0;
        bus_if.i_mode_down    = 1'b0;
        bus_if.i_time_zero    = 1'b0;
        #1;
        total++;
        if ({bus_if.o_tick, bus_if.o_run, bus_if.o_clear, bus_if.o_dir, bus_if.o_done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {bus_if.o_tick, bus_if.o_run, bus_if.o_clear, bus_if.o_dir, bus_if.o_done});
        end
        total++;
        if (bus_if.o_state !== STOP) begin
            bad++;
            $display("FAIL reset_state got=%0d want=%0d", bus_if.o_state, STOP);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        total++;
        if (bus_if.o_state !== STOP || bus_if.o_tick !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle state=%0d tick=%b want state=0 tick=0", bus_if.o_state, bus_if.o_tick);
        end
    endtask

    task automatic test_run_ticks;
        logic exp_tick;
        bus_if.i_btn_run_stop = 1'b1;
        cyc(3);
        total++;
        if (bus_if.o_state !== STOP) begin
            bad++;
            $display("FAIL run_latency_early state=%0d want=%0d", bus_if.o_state, STOP);
        end
        cyc(1);
        total++;
        if (bus_if.o_state !== RUN || bus_if.o_run !== 1'b1) begin
            bad++;
            $display("FAIL run_entry state=%0d run=%b want state=1 run=1", bus_if.o_state, bus_if.o_run);
        end
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 1) bus_if.i_btn_run_stop = 1'b0;
            exp_tick = (k % DIV == 0);
            total++;
            if (bus_if.o_tick !== exp_tick) begin
                bad++;
                $display("FAIL tick_period cycle=%0d got=%b want=%b", k, bus_if.o_tick, exp_tick);
            end
        end
        total++;
        if (bus_if.o_state !== RUN) begin
            bad++;
            $display("FAIL held_button_single_pulse state=%0d want=%0d", bus_if.o_state, RUN);
        end
    endtask

    task automatic test_pause_resume;
        bit   seen;
        logic exp_tick;
        wait_tick(20, seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL pause_sync_tick got=0 want=1");
        end
        cyc(1);
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        total++;
        if (bus_if.o_state !== STOP) begin
            bad++;
            $display("FAIL pause_stop state=%0d want=%0d", bus_if.o_state, STOP);
        end
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) bus_if.i_btn_run_stop = 1'b0;
            total++;
            if (bus_if.o_tick !== 1'b0 || bus_if.o_state !== STOP) begin
                bad++;
                $display("FAIL pause_idle cycle=%0d tick=%b state=%0d want tick=0 state=0", k, bus_if.o_tick, bus_if.o_state);
            end
        end
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        total++;
        if (bus_if.o_state !== RUN) begin
            bad++;
            $display("FAIL resume_entry state=%0d want=%0d", bus_if.o_state, RUN);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) bus_if.i_btn_run_stop = 1'b0;
            exp_tick = (k == 6 || k == 16);
            total++;
            if (bus_if.o_tick !== exp_tick) begin
                bad++;
                $display("FAIL resume_phase cycle=%0d got=%b want=%b", k, bus_if.o_tick, exp_tick);
            end
        end
    endtask

    task automatic test_clear_simul;
        logic exp_tick;
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        bus_if.i_btn_run_stop = 1'b0;
        total++;
        if (bus_if.o_state !== STOP) begin
            bad++;
            $display("FAIL simul_setup_stop state=%0d want=%0d", bus_if.o_state, STOP);
        end
        cyc(3);
        bus_if.i_btn_run_stop = 1'b1;
        bus_if.i_btn_clear    = 1'b1;
        cyc(4);
        total++;
        if (bus_if.o_state !== CLEAR || bus_if.o_clear !== 1'b1) begin
            bad++;
            $display("FAIL stop_simul_clear state=%0d clear=%b want state=2 clear=1", bus_if.o_state, bus_if.o_clear);
        end
        cyc(1);
        total++;
        if (bus_if.o_state !== STOP || bus_if.o_clear !== 1'b0) begin
            bad++;
            $display("FAIL clear_one_cycle state=%0d clear=%b want state=0 clear=0", bus_if.o_state, bus_if.o_clear);
        end
        bus_if.i_btn_run_stop = 1'b0;
        bus_if.i_btn_clear    = 1'b0;
        cyc(3);
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus_if.i_btn_run_stop = 1'b0;
            exp_tick = (k == 10);
            total++;
            if (bus_if.o_tick !== exp_tick) begin
                bad++;
                $display("FAIL cleared_divider cycle=%0d got=%b want=%b", k, bus_if.o_tick, exp_tick);
            end
        end
        cyc(2);
        bus_if.i_btn_run_stop = 1'b1;
        bus_if.i_btn_clear    = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (bus_if.o_clear !== 1'b0) begin
                bad++;
                $display("FAIL run_simul_no_clear cycle=%0d got=%b want=0", k, bus_if.o_clear);
            end
            if (k == 4) begin
                total++;
                if (bus_if.o_state !== STOP) begin
                    bad++;
                    $display("FAIL run_simul_stop state=%0d want=%0d", bus_if.o_state, STOP);
                end
            end
        end
        bus_if.i_btn_run_stop = 1'b0;
        bus_if.i_btn_clear    = 1'b0;
        cyc(3);
    endtask

    task automatic test_countdown_done;
        int ticks;
        int n;
        bus_if.i_mode_down = 1'b1;
        cyc(1);
        total++;
        if (bus_if.o_dir !== 1'b1) begin
            bad++;
            $display("FAIL dir_latch_down got=%b want=1", bus_if.o_dir);
        end
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        bus_if.i_btn_run_stop = 1'b0;
        ticks = 0;
        n = 0;
        while (ticks < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus_if.o_tick === 1'b1) ticks++;
        end
        total++;
        if (ticks != 3) begin
            bad++;
            $display("FAIL countdown_ticks got=%0d want=3", ticks);
        end
        bus_if.i_time_zero = 1'b1;
        cyc(1);
        total++;
        if (bus_if.o_state !== DONE || bus_if.o_done !== 1'b1 || bus_if.o_run !== 1'b0 || bus_if.o_tick !== 1'b0) begin
            bad++;
            $display("FAIL done_entry state=%0d done=%b run=%b tick=%b want state=3 done=1 run=0 tick=0",
                     bus_if.o_state, bus_if.o_done, bus_if.o_run, bus_if.o_tick);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            total++;
            if (bus_if.o_tick !== 1'b0 || bus_if.o_state !== DONE) begin
                bad++;
                $display("FAIL done_hold cycle=%0d tick=%b state=%0d want tick=0 state=3", k, bus_if.o_tick, bus_if.o_state);
            end
        end
        bus_if.i_btn_run_stop = 1'b1;
        cyc(6);
        total++;
        if (bus_if.o_state !== DONE) begin
            bad++;
            $display("FAIL done_ignores_run state=%0d want=%0d", bus_if.o_state, DONE);
        end
        bus_if.i_btn_run_stop = 1'b0;
        cyc(3);
        bus_if.i_btn_clear = 1'b1;
        cyc(4);
        total++;
        if (bus_if.o_state !== CLEAR) begin
            bad++;
            $display("FAIL done_clear state=%0d want=%0d", bus_if.o_state, CLEAR);
        end
        cyc(1);
        total++;
        if (bus_if.o_state !== STOP) begin
            bad++;
            $display("FAIL done_clear_to_stop state=%0d want=%0d", bus_if.o_state, STOP);
        end
        bus_if.i_btn_clear = 1'b0;
        cyc(3);
        bus_if.i_btn_run_stop = 1'b1;
        cyc(6);
        total++;
        if (bus_if.o_state !== STOP || bus_if.o_run !== 1'b0) begin
            bad++;
            $display("FAIL zero_blocks_run state=%0d run=%b want state=0 run=0", bus_if.o_state, bus_if.o_run);
        end
        bus_if.i_btn_run_stop = 1'b0;
        cyc(3);
    endtask

    task automatic test_direction;
        bus_if.i_time_zero = 1'b0;
        bus_if.i_mode_down = 1'b0;
        cyc(1);
        total++;
        if (bus_if.o_dir !== 1'b0) begin
            bad++;
            $display("FAIL dir_follow_up got=%b want=0", bus_if.o_dir);
        end
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        bus_if.i_btn_run_stop = 1'b0;
        bus_if.i_mode_down    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (bus_if.o_dir !== 1'b0 || bus_if.o_state !== RUN) begin
                bad++;
                $display("FAIL dir_held_in_run cycle=%0d dir=%b state=%0d want dir=0 state=1", k, bus_if.o_dir, bus_if.o_state);
            end
        end
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        total++;
        if (bus_if.o_state !== STOP || bus_if.o_dir !== 1'b0) begin
            bad++;
            $display("FAIL dir_at_stop state=%0d dir=%b want state=0 dir=0", bus_if.o_state, bus_if.o_dir);
        end
        cyc(1);
        total++;
        if (bus_if.o_dir !== 1'b1) begin
            bad++;
            $display("FAIL dir_after_stop got=%b want=1", bus_if.o_dir);
        end
        bus_if.i_btn_run_stop = 1'b0;
        bus_if.i_mode_down    = 1'b0;
        cyc(3);
    endtask

    task automatic test_async_reset;
        bit   seen;
        logic exp_tick;
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        bus_if.i_btn_run_stop = 1'b0;
        wait_tick(20, seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL areset_sync_tick got=0 want=1");
        end
        cyc(7);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus_if.o_tick, bus_if.o_run, bus_if.o_clear, bus_if.o_dir, bus_if.o_done} !== 5'b0 ||
            bus_if.o_state !== STOP) begin
            bad++;
            $display("FAIL areset_immediate outs=%b state=%0d want outs=00000 state=0",
                     {bus_if.o_tick, bus_if.o_run, bus_if.o_clear, bus_if.o_dir, bus_if.o_done}, bus_if.o_state);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            total++;
            if (bus_if.o_tick !== 1'b0 || bus_if.o_state !== STOP) begin
                bad++;
                $display("FAIL areset_idle cycle=%0d tick=%b state=%0d want tick=0 state=0", k, bus_if.o_tick, bus_if.o_state);
            end
        end
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus_if.i_btn_run_stop = 1'b0;
            exp_tick = (k == 10);
            total++;
            if (bus_if.o_tick !== exp_tick) begin
                bad++;
                $display("FAIL areset_first_tick cycle=%0d got=%b want=%b", k, bus_if.o_tick, exp_tick);
            end
        end
        bus_if.i_btn_run_stop = 1'b1;
        cyc(4);
        bus_if.i_btn_run_stop = 1'b0;
        cyc(3);
    endtask

    task automatic test_random;
        int         run_hold;
        int         clr_hold;
        logic [6:0] got;
        logic [6:0] exp;
        run_hold = 0;
        clr_hold = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            got = {bus_if.o_state, bus_if.o_tick, bus_if.o_dir, bus_if.o_run, bus_if.o_clear, bus_if.o_done};
            exp = {m_state, m_tick, m_dir, m_state == RUN, m_state == CLEAR, m_state == DONE};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random cycle=%0d got=%b want=%b (state,tick,dir,run,clear,done)", k, got, exp);
            end
            if (run_hold > 0) begin
                run_hold--;
                if (run_hold == 0) bus_if.i_btn_run_stop = 1'b0;
            end else if ($urandom % 16 == 0) begin
                bus_if.i_btn_run_stop = 1'b1;
                run_hold = $urandom_range(1, 6);
            end
            if (clr_hold > 0) begin
                clr_hold--;
                if (clr_hold == 0) bus_if.i_btn_clear = 1'b0;
            end else if ($urandom % 48 == 0) begin
                bus_if.i_btn_clear = 1'b1;
                clr_hold = $urandom_range(1, 6);
            end
            if ($urandom % 40 == 0) bus_if.i_mode_down = ~bus_if.i_mode_down;
            if ($urandom % 30 == 0) bus_if.i_time_zero = ~bus_if.i_time_zero;
            if ($urandom % 600 == 0) begin
                #2;
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
        end
        bus_if.i_btn_run_stop = 1'b0;
        bus_if.i_btn_clear    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_run_ticks();
        test_pause_resume();
        test_clear_simul();
        test_countdown_done();
        test_direction();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
